// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared registered bitwise logic unit.
// One request is accepted per cycle; its result appears one cycle later, tagged with the requester ID.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic {EMPTY, FULL} state_e;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NREQ_U) s = s - NREQ_U;
    return s[IDW-1:0];
  endfunction

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [IDW-1:0]   scan_idx [NREQ];
  logic [IDW-1:0]   grant_idx;
  logic             found;
  logic [NREQ-1:0]  grant;
  logic             can_accept;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result_d;
  logic [IDW-1:0]   rr_ptr_d;

  // Priority order starts at the round-robin pointer and wraps modulo NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
    assign scan_idx[gi] = wrap_add(rr_ptr_q, gi);
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[scan_idx[k]]) begin
        found     = 1'b1;
        grant_idx = scan_idx[k];
      end
    end
  end

  assign grant      = {{(NREQ-1){1'b0}}, found} << grant_idx;
  assign can_accept = (state_q == EMPTY) | (rsp_valid & rsp_ready);
  assign req_ready  = grant & {NREQ{can_accept}};
  assign accept     = found & can_accept;
  assign rr_ptr_d   = wrap_add(grant_idx, 1);

  always_comb begin
    op_sel   = req_op[2*int'(grant_idx) +: 2];
    a_sel    = req_a[WIDTH*int'(grant_idx) +: WIDTH];
    b_sel    = req_b[WIDTH*int'(grant_idx) +: WIDTH];
    result_d = a_sel & b_sel;
    case (op_sel)
      2'b00:   result_d = a_sel & b_sel;
      2'b01:   result_d = a_sel | b_sel;
      2'b10:   result_d = a_sel ^ b_sel;
      default: result_d = a_sel & ~b_sel;
    endcase
  end

  // An accept while FULL and draining overwrites the result in place, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q    <= FULL;
            rsp_data_q <= result_d;
            rsp_id_q   <= grant_idx;
            rr_ptr_q   <= rr_ptr_d;
          end
        end
        default: begin
          if (accept) begin
            rsp_data_q <= result_d;
            rsp_id_q   <= grant_idx;
            rr_ptr_q   <= rr_ptr_d;
          end else if (rsp_ready) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, round-robin order, back-pressure,
// pointer wrap, asynchronous reset mid-operation and idle behaviour.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  int total = 0;
  int bad   = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // Leaves the bench just after a negedge with reset released and nothing requesting.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
      $display("FAIL reset_outputs: valid=%b id=%0d data=%h, want 0/0/00000000", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("reset: valid=%b id=%0d data=%h", rsp_valid, rsp_id, rsp_data);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      $display("FAIL reset_idle_ready: got %b want 0000", req_ready);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    set_req(0, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL single_ready: got %b want 0001", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h00F0_1234) begin
      $display("FAIL single_rsp: valid=%b id=%0d data=%h, want 1/0/00f01234", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("single: id=%0d data=%h", rsp_id, rsp_data);
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL single_drain: valid=%b want 0", rsp_valid);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hAAAA_0000;
    exp_data[1] = 32'hFFFF_AAAA;
    exp_data[2] = 32'h5555_AAAA;
    exp_data[3] = 32'h0000_AAAA;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i[1:0], 32'hAAAA_AAAA, 32'hFFFF_0000);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #1;
      total++;
      if (req_ready !== (4'b0001 << g)) begin
        $display("FAIL rr_grant[%0d]: got %b want one-hot %0d", k, req_ready, g);
        bad++;
      end
      @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== g[1:0] || rsp_data !== exp_data[g]) begin
        $display("FAIL rr_rsp[%0d]: valid=%b id=%0d data=%h, want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, g, exp_data[g]);
        bad++;
      end
      $display("round_robin[%0d]: id=%0d data=%h", k, rsp_id, rsp_data);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(1, 2'b01, 32'h1234_0000, 32'h0000_5678);
    set_req(2, 2'b10, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
        $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
        bad++;
      end
      @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h1234_5678) begin
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d data=%h, want 1/1/12345678", k, rsp_valid, rsp_id, rsp_data);
        bad++;
      end
      $display("back_pressure[%0d]: id=%0d data=%h", k, rsp_id, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL bp_release_ready: got %b want 0100", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hF0F0_F0F0) begin
      $display("FAIL bp_no_bubble: valid=%b id=%0d data=%h, want 1/2/f0f0f0f0", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("back_pressure release: id=%0d data=%h", rsp_id, rsp_data);
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL bp_drain: valid=%b want 0", rsp_valid);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(3, 2'b00, 32'hFFFF_FFFF, 32'h1357_9BDF);
    set_req(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_FFFF);
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      $display("FAIL wrap_grant3: got %b want 1000", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    total++;
    if (rsp_id !== 2'd3 || rsp_data !== 32'h1357_9BDF) begin
      $display("FAIL wrap_rsp3: id=%0d data=%h, want 3/13579bdf", rsp_id, rsp_data);
      bad++;
    end
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL wrap_grant0: got %b want 0001", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'hFFFF_0000) begin
      $display("FAIL wrap_rsp0: valid=%b id=%0d data=%h, want 1/0/ffff0000", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("wrap: id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 2'b00, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      $display("FAIL arst_pre: valid=%b id=%0d, want 1/1", rsp_valid, rsp_id);
      bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
      $display("FAIL arst_drop: valid=%b id=%0d data=%h, want 0/0/00000000", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("async reset: valid=%b", rsp_valid);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL arst_no_replay: valid=%b want 0", rsp_valid);
      bad++;
    end
    @(negedge clk);
    set_req(0, 2'b01, 32'h0000_00F0, 32'h0000_000F);
    set_req(2, 2'b10, 32'h1111_1111, 32'h1111_0000);
    req_valid = 4'b0101;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL arst_ptr_reset: got %b want 0001", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL arst_grant2: got %b want 0100", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h0000_1111) begin
      $display("FAIL arst_rsp2: valid=%b id=%0d data=%h, want 1/2/00001111", rsp_valid, rsp_id, rsp_data);
      bad++;
    end
    $display("async reset recovery: id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
  endtask

  task automatic test_idle();
    do_reset();
    set_req(1, 2'b10, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    req_valid = 4'b0010;
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        $display("FAIL idle[%0d]: valid=%b ready=%b, want 0/0000", k, rsp_valid, req_ready);
        bad++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'h0000_FF00 + i, 32'hFFFF_FFFF);
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL idle_ptr: got %b want 0100", req_ready);
      bad++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    total++;
    if (rsp_id !== 2'd2 || rsp_data !== 32'h0000_FF02) begin
      $display("FAIL idle_rsp: id=%0d data=%h, want 2/0000ff02", rsp_id, rsp_data);
      bad++;
    end
    $display("idle: id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_wrap();
    test_async_reset();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
